// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, flush, hold-level stall
// and an optional 2-entry skid buffer that keeps in_ready off the out_ready path.
module pipe_skid_stage #(
    parameter int unsigned    DW         = 32,
    parameter logic [DW-1:0]  NOP_VAL    = {DW{1'b0}},
    parameter bit             SKID_EN    = 1'b1,
    parameter logic [2:0]     HOLD_LEVEL = 3'd2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    hold_flag_i,
    input  logic          flush_i,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [1:0]    occ
);

    logic          m_valid_r;
    logic [DW-1:0] m_data_r;
    logic          s_valid_r;
    logic [DW-1:0] s_data_r;
    logic          rst_done_r;

    logic          hold_s;
    logic          ready_base_s;
    logic          push_s;
    logic          pop_s;
    logic          m_valid_nx_s;
    logic [DW-1:0] m_data_nx_s;
    logic          s_valid_nx_s;
    logic [DW-1:0] s_data_nx_s;

    // Handshake qualifiers; rst_done_r keeps in_ready low until one clean edge after reset.
    always_comb begin
        hold_s = (hold_flag_i >= HOLD_LEVEL);
        if (SKID_EN) begin
            ready_base_s = !s_valid_r;
        end else begin
            ready_base_s = !m_valid_r | out_ready;
        end
        in_ready = ready_base_s & rst_done_r & rst & !hold_s & !flush_i;
        push_s   = in_valid & in_ready;
        pop_s    = m_valid_r & out_ready;
    end

    // Next-state for main and skid registers; invalid entries always carry NOP_VAL.
    always_comb begin
        m_valid_nx_s = m_valid_r;
        m_data_nx_s  = m_data_r;
        s_valid_nx_s = s_valid_r;
        s_data_nx_s  = s_data_r;
        if (flush_i) begin
            m_valid_nx_s = 1'b0;
            m_data_nx_s  = NOP_VAL;
            s_valid_nx_s = 1'b0;
            s_data_nx_s  = NOP_VAL;
        end else if (pop_s) begin
            if (s_valid_r) begin
                m_valid_nx_s = 1'b1;
                m_data_nx_s  = s_data_r;
                s_valid_nx_s = 1'b0;
                s_data_nx_s  = NOP_VAL;
            end else if (push_s) begin
                m_valid_nx_s = 1'b1;
                m_data_nx_s  = in_data;
            end else begin
                m_valid_nx_s = 1'b0;
                m_data_nx_s  = NOP_VAL;
            end
        end else if (push_s) begin
            if (!m_valid_r) begin
                m_valid_nx_s = 1'b1;
                m_data_nx_s  = in_data;
            end else begin
                s_valid_nx_s = 1'b1;
                s_data_nx_s  = in_data;
            end
        end else begin
            m_valid_nx_s = m_valid_r;
        end
    end

    // Storage registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_valid_r  <= 1'b0;
            m_data_r   <= NOP_VAL;
            s_valid_r  <= 1'b0;
            s_data_r   <= NOP_VAL;
            rst_done_r <= 1'b0;
        end else begin
            m_valid_r  <= m_valid_nx_s;
            m_data_r   <= m_data_nx_s;
            s_valid_r  <= s_valid_nx_s;
            s_data_r   <= s_data_nx_s;
            rst_done_r <= 1'b1;
        end
    end

    assign out_valid = m_valid_r;
    assign out_data  = m_data_r;
    assign occ       = {1'b0, m_valid_r} + {1'b0, s_valid_r};

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised pipeline stage register with a valid/ready handshake and an optional 2-entry skid buffer. It replaces the fixed per-field inter-stage registers with a single payload bus of configurable width. It adds back-pressure, flush, hold-level stalling and a programmable bubble value. It sits between any two core stages (IF/ID, ID/EX, EX/MEM) and carries the packed stage payload (instruction, address, operands, write-back controls).

## Interface
- DW, 32: payload width in bits, 1..256.
- NOP_VAL, {DW{1'b0}}: payload driven on out_data while out_valid=0; also the reset and flush value.
- SKID_EN, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- HOLD_LEVEL, 3'd2: stage is held when hold_flag_i >= HOLD_LEVEL.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- hold_flag_i  in  3  global hold level from the control unit.
- flush_i  in  1  discard all buffered payloads (branch/jump/trap).
- in_valid  in  1  upstream payload valid.
- in_data  in  DW  upstream payload.
- in_ready  out  1  stage accepts in_data this cycle.
- out_valid  out  1  out_data is a real payload.
- out_data  out  DW  payload to downstream stage.
- out_ready  in  1  downstream accepts out_data this cycle.
- occ  out  2  number of buffered entries (0..2; max 1 when SKID_EN=0).

## Operation
- Definitions:
  - hold = (hold_flag_i >= HOLD_LEVEL).
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Storage: main register M (drives out_data) and, if SKID_EN=1, skid register S. Each has a valid bit.
- Priority, highest first: reset, flush, normal.
- Reset (rst=0 at edge):
  - M and S invalid; out_data = NOP_VAL; occ = 0.
  - in_ready = 0 while rst=0.
- Flush (flush_i=1 at edge):
  - M and S invalid; out_data = NOP_VAL next cycle.
  - Any payload offered the same cycle is dropped; in_ready is forced 0 combinationally while flush_i=1.
  - A pop in the flush cycle still counts for the downstream stage.
- Hold:
  - in_ready forced 0, so no push.
  - The output side keeps draining: pop still advances S into M.
  - out_valid is not forced low by hold.
- SKID_EN=1 normal operation:
  - in_ready is registered: in_ready = !S.valid & !hold & rst & !flush_i. The hold/flush/rst terms are combinational gating on the registered term.
  - Push with M empty or popping: data goes to M.
  - Push with M full and not popping: data goes to S.
  - Pop with S valid: S moves to M and S becomes invalid. A simultaneous push cannot occur in this case because in_ready=0.
  - Order is strictly FIFO; no payload is duplicated or lost except on flush.
- SKID_EN=0 normal operation:
  - in_ready = (!M.valid | out_ready) & !hold & rst & !flush_i.
  - Push loads M.
  - Pop without push invalidates M and sets out_data to NOP_VAL.
- out_data equals NOP_VAL whenever out_valid=0, in both modes.
- occ = M.valid + S.valid.

## Timing
- Latency: a push at edge N gives out_valid=1 with that payload after edge N; it is visible in cycle N+1.
- Throughput: 1 payload per cycle with out_ready held at 1, in both modes.
- SKID_EN=1 back-pressure: when out_ready drops, one more payload is absorbed into S. in_ready falls one cycle after out_ready falls.
- SKID_EN=1 recovery: in_ready returns one cycle after the pop that empties S.
- Full (occ=2): in_ready=0; held until a pop.
- Empty (occ=0): out_valid=0; out_ready is ignored.
- flush_i and hold together: flush wins; the state is empty next cycle.
- Reset mid-transfer: all state is lost at the first edge with rst=0. in_ready stays 0 until the first edge with rst=1 has passed.
- No combinational path from in_valid/in_data to out_*.
- SKID_EN=1: no path from out_ready to in_ready.

## Test plan
- Reset and stream:
  - Stimulus: DW=32, NOP_VAL=32'h00000013, SKID_EN=1. Hold rst=0 for 3 cycles. Then drive in_valid=1 with data 1,2,3,4 on consecutive cycles, out_ready=1.
  - Required: out_data=0x13 and out_valid=0 during reset. Outputs 1,2,3,4 appear one cycle later, back-to-back; occ stays at 1.
- Back-pressure:
  - Stimulus: stream 10..15, out_ready=0 for cycles 3–5.
  - Required: occ reaches 2 and in_ready=0. No value is lost or duplicated; the output sequence is exactly 10..15.
- Flush:
  - Stimulus: occ=2 holding A, B. Pulse flush_i with in_valid=1 and data C.
  - Required: next cycle out_valid=0, out_data=0x13, occ=0. C never appears at the output.
- Hold level:
  - Stimulus: HOLD_LEVEL=2. hold_flag_i=1, then 2, then 3, with in_valid=1.
  - Required: in_ready=1, then 0, then 0. The buffered entry still drains with out_ready=1.
- SKID_EN=0:
  - Stimulus: stream 5,6,7 with out_ready toggling 1,0,1.
  - Required: in_ready follows out_ready in the same cycle while M is full. Outputs are 5,6,7 in order; occ is never more than 1.
- Mid-stream reset:
  - Stimulus: assert rst=0 for one cycle while occ=2.
  - Required: next cycle occ=0, out_valid=0, in_ready=0. in_ready=1 one cycle after rst returns to 1.
